// File: rtl/line_fill_responder.sv
// line_fill_responder
//   Backing-store responder below the last cache level. It serves whole-line
//   fills (mem -> master) and dirty-line writebacks (master -> mem) as
//   word-serial bursts that start a fixed LATENCY cycles after a request is
//   accepted.
// Ports
//   clock, reset     : clock; asynchronous active-low reset
//   request          : master wants a line transfer (held until done)
//   write, addr      : direction and line address, sampled at accept
//   wdata, wvalid    : writeback beat; ready = responder takes the beat
//   rdata, rvalid    : fill beat, one per cycle, no backpressure
//   done             : one-cycle completion pulse
//   busy             : high whenever not idle
module line_fill_responder #(
  parameter int ADDRBITS  = 32,
  parameter int WORDBITS  = 32,
  parameter int LINEITEMS = 16,
  parameter int MEMWORDS  = 4096,
  parameter int LATENCY   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                request,
  input  logic                write,
  input  logic [ADDRBITS-1:0] addr,
  input  logic [WORDBITS-1:0] wdata,
  input  logic                wvalid,
  output logic                ready,
  output logic [WORDBITS-1:0] rdata,
  output logic                rvalid,
  output logic                done,
  output logic                busy
);
  localparam int BYTESH = $clog2(WORDBITS / 8);
  localparam int BW     = $clog2(LINEITEMS);
  localparam int IW     = $clog2(MEMWORDS);
  localparam int LW     = IW - BW;
  localparam int CW     = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

  // Transfer latched at accept; later changes on write/addr are ignored.
  typedef struct packed {
    logic          wr;
    logic [LW-1:0] line;
  } xfer_t;

  logic [WORDBITS-1:0] mem [MEMWORDS];

  state_t        state, state_n;
  xfer_t         cur, cur_n;
  logic [CW-1:0] wcnt, wcnt_n;
  logic [BW-1:0] beat, beat_n;
  logic          mem_we;
  logic [IW-1:0] idx;

  // Line number drops the byte offset and the in-line word bits; keeping
  // only LW bits makes the index wrap modulo MEMWORDS.
  logic unused_addr;
  assign unused_addr = ^addr;

  assign idx   = {cur.line, beat};
  assign rdata = rvalid ? mem[idx] : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cur   <= '0;
      wcnt  <= '0;
      beat  <= '0;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      wcnt  <= wcnt_n;
      beat  <= beat_n;
    end
  end

  // Array is not reset; an abandoned writeback leaves earlier beats in place.
  always_ff @(posedge clock) begin
    if (mem_we) mem[idx] <= wdata;
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    wcnt_n  = wcnt;
    beat_n  = beat;
    mem_we  = 1'b0;
    ready   = 1'b0;
    rvalid  = 1'b0;
    done    = 1'b0;
    busy    = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (request) begin
          state_n     = S_WAIT;
          cur_n.wr    = write;
          cur_n.line  = addr[BYTESH + BW +: LW];
          wcnt_n      = CW'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (wcnt == '0) begin
          state_n = S_BURST;
          beat_n  = '0;
        end else begin
          wcnt_n = wcnt - 1'b1;
        end
      end
      S_BURST: begin
        if (cur.wr) begin
          ready = 1'b1;
          if (wvalid) begin
            mem_we = 1'b1;
            beat_n = beat + 1'b1;
            if (beat == BW'(LINEITEMS - 1)) state_n = S_DONE;
          end
        end else begin
          rvalid = 1'b1;
          beat_n = beat + 1'b1;
          if (beat == BW'(LINEITEMS - 1)) state_n = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule
